// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned,
// one multiplier bit per cycle with valid/ready handshakes on both sides.
module alu_iter_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic            neg;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    acc_sum;
    logic [PW-1:0]    result;

    // Operate on magnitudes; the sign is reapplied once at the end.
    always_comb begin
        mag_a   = (is_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
        mag_b   = (is_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
        acc_sum = acc + (mplier[0] ? mcand : '0);
        result  = neg ? (~acc_sum + PW'(1)) : acc_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            prod_hi   <= '0;
            prod_lo   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        mcand    <= {{WIDTH{1'b0}}, mag_a};
                        mplier   <= mag_b;
                        neg      <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= StCalc;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                StCalc: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        {prod_hi, prod_lo} <= result;
                        state              <= StDone;
                        out_valid          <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
